// File: rtl/debug_pkg.sv
// Shared types and 100 MHz default timing for the debug-state button path.
package debug_pkg;

   typedef enum logic [2:0] {
      StIdle       = 3'd0,
      StPressChk   = 3'd1,
      StPressed    = 3'd2,
      StRepeat     = 3'd3,
      StReleaseChk = 3'd4
   } btn_state_e;

   localparam int unsigned DefDebounceCycles = 1_000_000;  // 10 ms
   localparam int unsigned DefHoldCycles     = 50_000_000; // 500 ms
   localparam int unsigned DefRepeatCycles   = 20_000_000; // 200 ms
   localparam int unsigned DefCntW           = 26;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronise, debounce, one pulse per press plus
// optional auto-repeat while held.
module btn_debounce_pulse
   import debug_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
   parameter int unsigned REPEAT_CYCLES   = DefRepeatCycles,
   parameter bit          REPEAT_EN       = 1'b1,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_pulse,
   output logic btn_level,
   output logic btn_held
);

   localparam logic [CNT_W-1:0] DebTc  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldTc = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] RepTc  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CNT_W-1:0] One    = CNT_W'(1);

   logic             btn_sync;
   btn_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_raw),
      .q   (btn_sync)
   );

   // Release is always tested first, so it beats a coincident terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         btn_pulse <= 1'b0;
         btn_level <= 1'b0;
         btn_held  <= 1'b0;
      end else begin
         btn_pulse <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (btn_sync) begin
                  state_q <= StPressChk;
                  cnt_q   <= '0;
               end
            end
            StPressChk: begin
               if (!btn_sync) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (cnt_q == DebTc) begin
                  state_q   <= StPressed;
                  cnt_q     <= '0;
                  btn_pulse <= 1'b1;
                  btn_level <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + One;
               end
            end
            StPressed: begin
               if (!btn_sync) begin
                  state_q <= StReleaseChk;
                  cnt_q   <= '0;
               end else if (cnt_q != HoldTc) begin
                  cnt_q <= cnt_q + One;
               end else if (REPEAT_EN) begin
                  state_q   <= StRepeat;
                  cnt_q     <= '0;
                  btn_pulse <= 1'b1;
                  btn_held  <= 1'b1;
               end
               // Without auto-repeat the hold timer simply parks at its terminal value.
            end
            StRepeat: begin
               if (!btn_sync) begin
                  state_q  <= StReleaseChk;
                  cnt_q    <= '0;
                  btn_held <= 1'b0;
               end else if (cnt_q == RepTc) begin
                  cnt_q     <= '0;
                  btn_pulse <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + One;
               end
            end
            StReleaseChk: begin
               if (btn_sync) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
               end else if (cnt_q == DebTc) begin
                  state_q   <= StIdle;
                  cnt_q     <= '0;
                  btn_level <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + One;
               end
            end
            default: begin
               state_q   <= StIdle;
               cnt_q     <= '0;
               btn_level <= 1'b0;
               btn_held  <= 1'b0;
            end
         endcase
      end
   end

endmodule
